// File: rtl/alu_pkg.sv
// Shared constants for the 16-bit Harvard processor ALU datapath units.
package alu_pkg;

    // Native datapath width; default operand width for ALU sub-units.
    localparam int unsigned DATA_W = 16;

    // Returns 1 when every bit of a NAND result is zero, i.e. both operands were all ones.
    function automatic logic nand_all_zero(input logic [DATA_W-1:0] y);
        return ~|y;
    endfunction

endpackage

// File: rtl/nand_gate_16b_if.sv
// Operand/result bundle for the NAND unit. The producer uses master, the unit uses slave.
interface nand_gate_16b_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             all_zero;

    modport master (
        output a,
        output b,
        output in_valid,
        input  out,
        input  out_valid,
        input  all_zero
    );

    modport slave (
        input  a,
        input  b,
        input  in_valid,
        output out,
        output out_valid,
        output all_zero
    );

endinterface

// File: rtl/nand_bit.sv
// Single-bit NAND primitive; the building block for the wider logic units.
module nand_bit (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = ~(a & b);

endmodule

// File: rtl/nand_gate_16b.sv
// Bitwise NAND datapath unit with optional one-cycle registered output stage.
module nand_gate_16b
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = DATA_W,
    parameter bit          REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    nand_gate_16b_if.slave   bus
);

    logic [WIDTH-1:0] nand_y;
    logic             nand_zero;

    // Bits are independent: one primitive per bit, no cross-bit logic in the core.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nand_bit u_nand_bit (
            .a (bus.a[i]),
            .b (bus.b[i]),
            .y (nand_y[i])
        );
    end

    // Zero result only occurs when both operands are all ones.
    assign nand_zero = ~|nand_y;

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] out_q;
        logic             valid_q;
        logic             zero_q;

        // Output register bank; data holds when no valid operands arrive.
        always_ff @(posedge clk) begin
            if (rst) begin
                out_q   <= '1;
                valid_q <= 1'b0;
                zero_q  <= 1'b0;
            end else begin
                valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    out_q  <= nand_y;
                    zero_q <= nand_zero;
                end
            end
        end

        assign bus.out       = out_q;
        assign bus.out_valid = valid_q;
        assign bus.all_zero  = zero_q;
    end else begin : g_comb
        // Clock and reset have no function in the passthrough configuration.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;

        assign bus.out       = nand_y;
        assign bus.out_valid = bus.in_valid;
        assign bus.all_zero  = nand_zero;
    end

endmodule

// File: tb/tb_nand_gate_16b.sv
// Self-checking bench: registered and combinational NAND units driven with identical stimulus.
module tb_nand_gate_16b;

    logic clk;
    logic rst;

    nand_gate_16b_if #(.WIDTH(16)) if_r ();
    nand_gate_16b_if #(.WIDTH(16)) if_c ();

    nand_gate_16b #(.WIDTH(16), .REG_OUT(1'b1)) u_dut_reg (
        .clk (clk),
        .rst (rst),
        .bus (if_r.slave)
    );

    nand_gate_16b #(.WIDTH(16), .REG_OUT(1'b0)) u_dut_comb (
        .clk (clk),
        .rst (rst),
        .bus (if_c.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    // Reference state for the registered unit.
    logic [15:0] m_out;
    logic        m_valid;
    logic        m_zero;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus: check the combinational unit before the edge,
    // then the registered unit just after it.
    task automatic step(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tv, input logic tr);
        logic [15:0] both;
        both       = ta & tb_v;
        rst        = tr;
        if_r.a     = ta;
        if_r.b     = tb_v;
        if_r.in_valid = tv;
        if_c.a     = ta;
        if_c.b     = tb_v;
        if_c.in_valid = tv;
        #1;
        chk("comb_out", if_c.out, 16'hFFFF - both);
        chk("comb_valid", {15'd0, if_c.out_valid}, {15'd0, tv});
        chk("comb_zero", {15'd0, if_c.all_zero}, {15'd0, both == 16'hFFFF});
        @(posedge clk);
        #1;
        if (tr) begin
            m_out   = 16'hFFFF;
            m_valid = 1'b0;
            m_zero  = 1'b0;
        end else begin
            m_valid = tv;
            if (tv) begin
                m_out  = 16'hFFFF - both;
                m_zero = (both == 16'hFFFF);
            end
        end
        chk("reg_out", if_r.out, m_out);
        chk("reg_valid", {15'd0, if_r.out_valid}, {15'd0, m_valid});
        chk("reg_zero", {15'd0, if_r.all_zero}, {15'd0, m_zero});
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rv;
        logic        rr;
        tests   = 0;
        fails   = 0;
        m_out   = 16'hFFFF;
        m_valid = 1'b0;
        m_zero  = 1'b0;

        // Reset held for two cycles with junk operands.
        step(16'h1234, 16'hFFFF, 1'b1, 1'b1);
        step(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        chk("rst_out", if_r.out, 16'hFFFF);
        chk("rst_valid", {15'd0, if_r.out_valid}, 16'd0);
        chk("rst_zero", {15'd0, if_r.all_zero}, 16'd0);

        // First results and back-to-back throughput.
        step(16'h0000, 16'h0001, 1'b1, 1'b0);
        chk("first_out", if_r.out, 16'hFFFF);
        chk("first_valid", {15'd0, if_r.out_valid}, 16'd1);
        step(16'h000E, 16'h0015, 1'b1, 1'b0);
        chk("b2b_0", if_r.out, 16'hFFFB);
        step(16'h0003, 16'h00DD, 1'b1, 1'b0);
        chk("b2b_1", if_r.out, 16'hFFFE);
        chk("b2b_valid", {15'd0, if_r.out_valid}, 16'd1);

        // all_zero boundary.
        step(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        chk("ones_out", if_r.out, 16'h0000);
        chk("ones_zero", {15'd0, if_r.all_zero}, 16'd1);
        step(16'hAAAA, 16'h5555, 1'b1, 1'b0);
        chk("alt_out", if_r.out, 16'hFFFF);
        chk("alt_zero", {15'd0, if_r.all_zero}, 16'd0);

        // Hold behaviour with in_valid low.
        step(16'hF0F0, 16'hFF00, 1'b1, 1'b0);
        chk("pre_hold", if_r.out, 16'h0FFF);
        for (int i = 0; i < 3; i++) begin
            step(16'hFFFF, 16'h1234, 1'b0, 1'b0);
            chk("hold_out", if_r.out, 16'h0FFF);
            chk("hold_valid", {15'd0, if_r.out_valid}, 16'd0);
        end

        // Reset in the middle of a valid stream discards that sample.
        step(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        step(16'h0001, 16'h0001, 1'b1, 1'b1);
        chk("mid_rst_out", if_r.out, 16'hFFFF);
        chk("mid_rst_valid", {15'd0, if_r.out_valid}, 16'd0);
        chk("mid_rst_zero", {15'd0, if_r.all_zero}, 16'd0);
        step(16'h00FF, 16'h0F0F, 1'b1, 1'b0);
        chk("post_rst_out", if_r.out, 16'hFFF0);

        // Randomised run checked against the arithmetic reference.
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                ra = 16'hFFFF;
                rb = 16'hFFFF;
            end
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 63) == 0);
            step(ra, rb, rv, rr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
